// File: rtl/fwd_select.sv
// Operand forwarding selector.
// Keeps a short history of recent producer results and picks the youngest
// matching value for an operand request. If nothing matches, the register-file
// value is used. The selected operand and its source tag are registered.
module fwd_select #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             wr_valid_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_valid_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             hit_o,
    output logic [3:0]       src_o
);

    // Entry 0 holds the youngest result.
    logic [DEPTH-1:0] hist_valid;
    logic [AW-1:0]    hist_addr [DEPTH];
    logic [WIDTH-1:0] hist_data [DEPTH];

    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;
    logic [3:0]       sel_src;

    // Pick the youngest matching source. Scan oldest to youngest so that the
    // youngest match is the last assignment; the same-cycle write is checked
    // last of all. Register 0 is hardwired and never forwarded.
    always_comb begin
        sel_data = rd_data_i;
        sel_hit  = 1'b0;
        sel_src  = 4'd0;
        if (rd_addr_i != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hist_valid[k] && (hist_addr[k] == rd_addr_i)) begin
                    sel_data = hist_data[k];
                    sel_hit  = 1'b1;
                    sel_src  = 4'(k + 2);
                end
            end
            if (wr_valid_i && (wr_addr_i == rd_addr_i)) begin
                sel_data = wr_data_i;
                sel_hit  = 1'b1;
                sel_src  = 4'd1;
            end
        end
    end

    // History shift buffer: reset and flush clear valids, stall holds,
    // otherwise shift in the current write (an invalid bubble if none).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_valid <= '0;
        end else if (flush_i) begin
            hist_valid <= '0;
        end else if (!stall_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                hist_valid[k] <= hist_valid[k-1];
                hist_addr[k]  <= hist_addr[k-1];
                hist_data[k]  <= hist_data[k-1];
            end
            hist_valid[0] <= wr_valid_i;
            hist_addr[0]  <= wr_addr_i;
            hist_data[0]  <= wr_data_i;
        end
    end

    // Output registers: cleared by reset, frozen by a stall. A flush only
    // affects history, so outputs still capture the pre-flush selection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            hit_o   <= 1'b0;
            src_o   <= 4'd0;
        end else if (!stall_i || flush_i) begin
            data_o  <= sel_data;
            valid_o <= rd_valid_i;
            hit_o   <= sel_hit;
            src_o   <= sel_src;
        end
    end

endmodule

// File: tb/tb_fwd_select.sv
// Directed bench for fwd_select: each task drives one scenario and compares
// the registered outputs against hand-computed values.
module tb_fwd_select;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             stall_i;
    logic             flush_i;
    logic             wr_valid_i;
    logic [AW-1:0]    wr_addr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_valid_i;
    logic [AW-1:0]    rd_addr_i;
    logic [WIDTH-1:0] rd_data_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             hit_o;
    logic [3:0]       src_o;

    int checks   = 0;
    int failures = 0;

    fwd_select #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_valid_i (rd_valid_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_i  (rd_data_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .hit_o      (hit_o),
        .src_o      (src_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        rst_i      = 1'b0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        rd_valid_i = 1'b0;
        rd_addr_i  = '0;
        rd_data_i  = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] rf);
        rd_valid_i = 1'b1;
        rd_addr_i  = a;
        rd_data_i  = rf;
    endtask

    task automatic clean_history();
        set_idle();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_i = 1'b1;
        step();
        step();
        checks++; if (data_o !== 32'h0)  begin failures++; $display("FAIL reset_data got=%h exp=%h", data_o, 32'h0); end
        checks++; if (valid_o !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (hit_o !== 1'b0)    begin failures++; $display("FAIL reset_hit got=%b exp=0", hit_o); end
        checks++; if (src_o !== 4'd0)    begin failures++; $display("FAIL reset_src got=%0d exp=0", src_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_hist_hit();
        clean_history();
        do_write(5'd5, 32'h11);
        step();
        set_idle();
        do_read(5'd5, 32'hAA);
        step();
        checks++; if (data_o !== 32'h11) begin failures++; $display("FAIL hist_hit_data got=%h exp=%h", data_o, 32'h11); end
        checks++; if (valid_o !== 1'b1)  begin failures++; $display("FAIL hist_hit_valid got=%b exp=1", valid_o); end
        checks++; if (hit_o !== 1'b1)    begin failures++; $display("FAIL hist_hit_hit got=%b exp=1", hit_o); end
        checks++; if (src_o !== 4'd2)    begin failures++; $display("FAIL hist_hit_src got=%0d exp=2", src_o); end
    endtask

    task automatic test_same_cycle_and_age_out();
        clean_history();
        do_write(5'd7, 32'h22);
        do_read(5'd7, 32'hBB);
        step();
        checks++; if (data_o !== 32'h22) begin failures++; $display("FAIL same_cycle_data got=%h exp=%h", data_o, 32'h22); end
        checks++; if (src_o !== 4'd1)    begin failures++; $display("FAIL same_cycle_src got=%0d exp=1", src_o); end
        set_idle();
        do_write(5'd7, 32'h33);
        step();
        set_idle();
        for (int i = 0; i < DEPTH + 1; i++) step();
        do_read(5'd7, 32'hBB);
        step();
        checks++; if (data_o !== 32'hBB) begin failures++; $display("FAIL age_out_data got=%h exp=%h", data_o, 32'hBB); end
        checks++; if (hit_o !== 1'b0)    begin failures++; $display("FAIL age_out_hit got=%b exp=0", hit_o); end
        checks++; if (src_o !== 4'd0)    begin failures++; $display("FAIL age_out_src got=%0d exp=0", src_o); end
    endtask

    task automatic test_oldest_entry();
        clean_history();
        do_write(5'd9, 32'h99);
        step();
        set_idle();
        for (int i = 0; i < DEPTH - 1; i++) step();
        do_read(5'd9, 32'h5A);
        step();
        checks++; if (data_o !== 32'h99)       begin failures++; $display("FAIL oldest_data got=%h exp=%h", data_o, 32'h99); end
        checks++; if (src_o !== 4'(DEPTH + 1)) begin failures++; $display("FAIL oldest_src got=%0d exp=%0d", src_o, DEPTH + 1); end
        step();
        checks++; if (data_o !== 32'h5A)       begin failures++; $display("FAIL evicted_data got=%h exp=%h", data_o, 32'h5A); end
        checks++; if (hit_o !== 1'b0)          begin failures++; $display("FAIL evicted_hit got=%b exp=0", hit_o); end
    endtask

    task automatic test_youngest();
        clean_history();
        do_write(5'd3, 32'h1);
        step();
        do_write(5'd3, 32'h2);
        step();
        set_idle();
        do_read(5'd3, 32'hEE);
        step();
        checks++; if (data_o !== 32'h2)  begin failures++; $display("FAIL youngest_data got=%h exp=%h", data_o, 32'h2); end
        checks++; if (src_o !== 4'd2)    begin failures++; $display("FAIL youngest_src got=%0d exp=2", src_o); end
    endtask

    task automatic test_reg_zero();
        clean_history();
        do_write(5'd0, 32'hFF);
        do_read(5'd0, 32'h0);
        step();
        checks++; if (data_o !== 32'h0)  begin failures++; $display("FAIL r0_data got=%h exp=%h", data_o, 32'h0); end
        checks++; if (hit_o !== 1'b0)    begin failures++; $display("FAIL r0_hit got=%b exp=0", hit_o); end
        checks++; if (src_o !== 4'd0)    begin failures++; $display("FAIL r0_src got=%0d exp=0", src_o); end
        set_idle();
        do_read(5'd0, 32'h0);
        step();
        checks++; if (hit_o !== 1'b0)    begin failures++; $display("FAIL r0_hist_hit got=%b exp=0", hit_o); end
    endtask

    task automatic test_stall();
        clean_history();
        do_write(5'd4, 32'h44);
        do_read(5'd4, 32'h10);
        step();
        set_idle();
        stall_i = 1'b1;
        do_write(5'd4, 32'h55);
        do_read(5'd4, 32'h20);
        rd_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (data_o !== 32'h44 || src_o !== 4'd1 || valid_o !== 1'b1 || hit_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_frozen cycle=%0d got data=%h src=%0d valid=%b hit=%b exp data=44 src=1 valid=1 hit=1",
                         i, data_o, src_o, valid_o, hit_o);
            end
        end
        set_idle();
        do_read(5'd4, 32'h30);
        step();
        checks++; if (data_o !== 32'h44) begin failures++; $display("FAIL post_stall_data got=%h exp=%h", data_o, 32'h44); end
        checks++; if (src_o !== 4'd2)    begin failures++; $display("FAIL post_stall_src got=%0d exp=2", src_o); end
    endtask

    task automatic test_flush_and_reset();
        clean_history();
        do_write(5'd6, 32'h66);
        step();
        flush_i = 1'b1;
        do_write(5'd6, 32'h77);
        do_read(5'd6, 32'hCC);
        step();
        checks++; if (data_o !== 32'h77) begin failures++; $display("FAIL flush_edge_data got=%h exp=%h", data_o, 32'h77); end
        checks++; if (src_o !== 4'd1)    begin failures++; $display("FAIL flush_edge_src got=%0d exp=1", src_o); end
        set_idle();
        do_read(5'd6, 32'hCC);
        step();
        checks++; if (data_o !== 32'hCC) begin failures++; $display("FAIL post_flush_data got=%h exp=%h", data_o, 32'hCC); end
        checks++; if (hit_o !== 1'b0)    begin failures++; $display("FAIL post_flush_hit got=%b exp=0", hit_o); end
        set_idle();
        do_write(5'd8, 32'h88);
        step();
        set_idle();
        rst_i = 1'b1;
        stall_i = 1'b1;
        do_read(5'd8, 32'h12);
        step();
        checks++; if (data_o !== 32'h0 || valid_o !== 1'b0 || hit_o !== 1'b0 || src_o !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset got data=%h valid=%b hit=%b src=%0d exp all zero", data_o, valid_o, hit_o, src_o);
        end
        set_idle();
        do_read(5'd8, 32'hDD);
        step();
        checks++; if (data_o !== 32'hDD) begin failures++; $display("FAIL post_reset_data got=%h exp=%h", data_o, 32'hDD); end
        checks++; if (valid_o !== 1'b1 || hit_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_flags got valid=%b hit=%b exp valid=1 hit=0", valid_o, hit_o);
        end
    endtask

    task automatic test_back_to_back();
        clean_history();
        do_write(5'd10, 32'h100);
        step();
        for (int i = 1; i <= 4; i++) begin
            do_write(5'(10 + i), 32'h100 + 32'(i));
            do_read(5'(9 + i), 32'hDEAD);
            step();
            checks++; if (data_o !== 32'h100 + 32'(i - 1) || src_o !== 4'd2) begin
                failures++;
                $display("FAIL back_to_back i=%0d got data=%h src=%0d exp data=%h src=2",
                         i, data_o, src_o, 32'h100 + 32'(i - 1));
            end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_hist_hit();
        test_same_cycle_and_age_out();
        test_oldest_entry();
        test_youngest();
        test_reg_zero();
        test_stall();
        test_flush_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_select.md
FWD_SELECT -- requirements
Module: fwd_select

Interface
REQ-001 Parameter WIDTH, 32, operand/result data width in bits.
REQ-002 Parameter AW, 5, register address width in bits.
REQ-003 Parameter DEPTH, 3, number of in-flight producer results tracked (1..8).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock, all state changes on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 stall_i  in  1  freeze history and output registers.
REQ-007 flush_i  in  1  invalidate all history entries.
REQ-008 wr_valid_i  in  1  producer result valid this cycle.
REQ-009 wr_addr_i  in  AW  producer destination register.
REQ-010 wr_data_i  in  WIDTH  producer result.
REQ-011 rd_valid_i  in  1  operand request valid.
REQ-012 rd_addr_i  in  AW  operand source register.
REQ-013 rd_data_i  in  WIDTH  register-file value for rd_addr_i.
REQ-014 data_o  out  WIDTH  selected operand, registered.
REQ-015 valid_o  out  1  data_o valid, registered.
REQ-016 hit_o  out  1  data_o came from a forwarded source.
REQ-017 src_o  out  4  source code: 0 = register file, 1 = same-cycle write, k+2 = history entry k.

Function
REQ-018 History SHALL be a DEPTH-entry shift buffer of {valid, addr, data}; entry 0 youngest.
REQ-019 On a clock edge with stall_i=0, flush_i=0: entry 0 <= {wr_valid_i, wr_addr_i, wr_data_i}, entry k <= entry k-1, entry DEPTH-1 discarded (shift occurs even if wr_valid_i=0, inserting an invalid bubble).
REQ-020 flush_i=1 SHALL clear all valid bits at the edge and discard the same-cycle write; flush_i has priority over stall_i.
REQ-021 stall_i=1 (flush_i=0) SHALL hold history, data_o, valid_o, hit_o, src_o unchanged.
REQ-022 Match priority, evaluated combinationally, youngest first: same-cycle write (wr_valid_i and wr_addr_i==rd_addr_i), then entry 0, entry 1, ... entry DEPTH-1; first match wins.
REQ-023 rd_addr_i==0 SHALL never match; selects rd_data_i, src 0.
REQ-024 Entries with valid=0 SHALL never match.
REQ-025 No match: selected value = rd_data_i, src 0, hit 0.
REQ-026 Latency: selection for request at edge N appears on data_o/valid_o/hit_o/src_o after edge N (one cycle).
REQ-027 valid_o <= rd_valid_i on each non-stalled edge; when rd_valid_i=0, data_o, hit_o, src_o SHALL still update but are don't-care to consumers.
REQ-028 Same-cycle flush_i=1 with rd_valid_i=1: selection uses pre-flush history and same-cycle write (flush affects only state), output registers update normally.
REQ-029 Duplicate addresses in history are legal; only the youngest SHALL be selected.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 rst_i=1 at an edge SHALL clear all history valid bits and set data_o=0, valid_o=0, hit_o=0, src_o=0; reset has priority over flush_i and stall_i.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight history; first post-reset request with no same-cycle write returns rd_data_i.

Verification
REQ-033 Write r5=0x11 at edge 0, read r5 rd_data_i=0xAA at edge 1 -> after edge 1: data_o=0x11, hit_o=1, src_o=2.
REQ-034 Same cycle write r7=0x22 and read r7 (rd_data_i=0xBB) -> data_o=0x22, src_o=1; write r7=0x33 next edge then after DEPTH+1 idle edges read r7 -> data_o=rd_data_i, hit_o=0.
REQ-035 Writes r3=0x1, r3=0x2 on consecutive edges, read r3 -> data_o=0x2, src_o=2 (youngest).
REQ-036 Write r0=0xFF, read r0 with rd_data_i=0 -> data_o=0, hit_o=0, src_o=0.
REQ-037 Write r4=0x44, stall_i=1 for 3 edges with new writes r4=0x55 presented, release, read r4 -> data_o=0x44, src_o=2; outputs frozen during stall.
REQ-038 Write r6=0x66, flush_i=1 with write r6=0x77, read r6 (rd_data_i=0xCC) -> data_o=0xCC, hit_o=0; rst_i=1 -> all outputs 0 next edge.
